// File: rtl/exp_result_collector_pkg.sv
`default_nettype none
//==========================================================================
// exp_result_collector_pkg : shared state encodings and default sizes
// Revision: 1.0
//==========================================================================
package exp_result_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_INT_W   = 2;
  localparam int DEF_FRAC_W  = 16;
  localparam int RESULT_W    = DEF_INT_W + DEF_FRAC_W;
  localparam int NDONE_W     = 8;

endpackage
`default_nettype wire

// File: rtl/exp_result_collector_if.sv
`default_nettype none
//==========================================================================
// exp_result_collector_if : Wrapper handshake, control/status and read port
// Revision: 1.0
//==========================================================================
interface exp_result_collector_if
  import exp_result_collector_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
);
  localparam int RES_W = INT_W + FRAC_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               run;
  logic               clr_err;
  logic               done;
  logic [INT_W-1:0]   intpart;
  logic [FRAC_W-1:0]  fracpart;
  logic               start;
  logic               rd_en;
  logic [RES_W-1:0]   rd_data;
  logic               empty;
  logic               full;
  logic [CNT_W-1:0]   count;
  logic               busy;
  logic               err;
  logic [NDONE_W-1:0] n_done;

  modport master (
    input  run, clr_err, done, intpart, fracpart, rd_en,
    output start, rd_data, empty, full, count, busy, err, n_done
  );

  modport slave (
    output run, clr_err, done, intpart, fracpart, rd_en,
    input  start, rd_data, empty, full, count, busy, err, n_done
  );

endinterface
`default_nettype wire

// File: rtl/exp_result_collector_result_fifo.sv
`default_nettype none
//==========================================================================
// result_fifo : circular result buffer with show-ahead read port
// Revision: 1.0
//==========================================================================
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so natural pointer overflow gives the wrap
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/exp_result_collector.sv
`default_nettype none
//==========================================================================
// exp_result_collector : issues Wrapper requests, captures results, watchdog
// Revision: 1.0
//==========================================================================
module exp_result_collector
  import exp_result_collector_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int INT_W   = DEF_INT_W,
  parameter int FRAC_W  = DEF_FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  exp_result_collector_if.master bus
);
  localparam int RES_W = INT_W + FRAC_W;
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [WD_W-1:0]    wd_q, wd_d, wd_inc;
  logic               err_q, err_d;
  logic [NDONE_W-1:0] n_done_q, n_done_d;
  logic               wr_en;

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    wd_d     = wd_q;
    wd_inc   = wd_q + 1'b1;
    err_d    = err_q && !bus.clr_err;
    n_done_d = n_done_q;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run && !bus.full) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the last watchdog cycle still counts as an answer
        if (bus.done) begin
          wr_en    = 1'b1;
          n_done_d = n_done_q + 8'd1;
          state_d  = ST_IDLE;
        end else if (wd_inc == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    start_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      n_done_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      n_done_q <= n_done_d;
    end
  end

  assign bus.start  = start_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.err    = err_q;
  assign bus.n_done = n_done_q;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({bus.intpart, bus.fracpart}),
    .rd_en   (bus.rd_en),
    .rd_data (bus.rd_data),
    .empty   (bus.empty),
    .full    (bus.full),
    .count   (bus.count)
  );

endmodule
`default_nettype wire

// File: tb/tb_exp_result_collector.sv
`default_nettype none
//==========================================================================
// tb_exp_result_collector : directed scoreboard bench for the collector
// Revision: 1.0
//==========================================================================
module tb_exp_result_collector;
  import exp_result_collector_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int INT_W   = 2;
  localparam int FRAC_W  = 16;
  localparam int RES_W   = INT_W + FRAC_W;

  logic clk = 1'b0;
  logic rst;

  exp_result_collector_if #(.DEPTH(DEPTH), .INT_W(INT_W), .FRAC_W(FRAC_W)) bus ();

  exp_result_collector #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .INT_W   (INT_W),
    .FRAC_W  (FRAC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_start = 0;

  logic [RES_W-1:0] q [$];
  logic [7:0]       exp_n_done = 8'd0;
  int               start_base;
  int               first_err, first_start, last_start;
  logic             err_sticky, err_setwins;

  always @(posedge clk) begin
    if (bus.start === 1'b1) n_start <= n_start + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_start();
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.start === 1'b1) seen = 1'b1;
    end
    check("start_seen", 32'(seen), 32'd1);
  endtask

  // Wrapper model: answers lat cycles after the start pulse, optionally popping too
  task automatic serve(input int lat, input logic [RES_W-1:0] val, input bit pop);
    repeat (lat) @(negedge clk);
    if (pop) begin
      check("head_concurrent", 32'(bus.rd_data), 32'(q[0]));
      void'(q.pop_front());
      bus.rd_en = 1'b1;
    end
    {bus.intpart, bus.fracpart} = val;
    bus.done = 1'b1;
    q.push_back(val);
    exp_n_done = exp_n_done + 8'd1;
    @(negedge clk);
    bus.done  = 1'b0;
    bus.rd_en = 1'b0;
    check("count_after_capture", 32'(bus.count), 32'(q.size()));
    check("n_done", 32'(bus.n_done), 32'(exp_n_done));
  endtask

  task automatic pop_check(input string tag);
    logic [RES_W-1:0] exp_v;
    check({tag, "_nonempty"}, 32'(bus.empty), 32'd0);
    exp_v = q.pop_front();
    check(tag, 32'(bus.rd_data), 32'(exp_v));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check({tag, "_count"}, 32'(bus.count), 32'(q.size()));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst         = 1'b1;
    bus.run     = 1'b1;
    bus.clr_err = 1'b0;
    bus.done    = 1'b0;
    bus.intpart = '0;
    bus.fracpart = '0;
    bus.rd_en   = 1'b0;

    // Asynchronous reset with run held high
    #11 rst = 1'b0;
    #1;
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_n_done", 32'(bus.n_done), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_hold_start", 32'(bus.start), 32'd0);
    check("rst_hold_busy", 32'(bus.busy), 32'd0);
    check("rst_hold_full", 32'(bus.full), 32'd0);
    @(negedge clk);
    start_base = n_start;
    rst = 1'b1;

    // Single capture, done 10 cycles after start; run dropped mid-request
    wait_start();
    bus.run = 1'b0;
    serve(10, 18'h1B7E1, 1'b0);
    check("single_rd_data", 32'(bus.rd_data), 32'h1B7E1);
    repeat (3) @(negedge clk);
    check("single_one_start", 32'(n_start - start_base), 32'd1);
    check("single_idle", 32'(bus.busy), 32'd0);
    pop_check("single_pop");
    check("single_empty", 32'(bus.empty), 32'd1);
    check("single_rd_zero", 32'(bus.rd_data), 32'd0);

    // Fill to DEPTH, stall, then resume after one pop
    bus.run = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wait_start();
      serve(2, RES_W'(18'h10000 + i), 1'b0);
    end
    check("fill_full", 32'(bus.full), 32'd1);
    start_base = n_start;
    repeat (8) @(negedge clk);
    check("stall_no_start", 32'(n_start - start_base), 32'd0);
    check("stall_idle", 32'(bus.busy), 32'd0);
    pop_check("fill_pop0");
    wait_start();
    bus.run = 1'b0;
    serve(2, 18'h10004, 1'b0);
    check("refill_full", 32'(bus.full), 32'd1);
    for (int i = 1; i <= DEPTH; i++) pop_check("fill_drain");
    check("fill_empty", 32'(bus.empty), 32'd1);

    // Back-to-back requests with pops on the capture cycle, across pointer wrap
    bus.run = 1'b1;
    wait_start();
    serve(1, 18'h2A5A0, 1'b0);
    wait_start();
    serve(1, 18'h2A5A1, 1'b0);
    wait_start();
    serve(1, 18'h2A5A2, 1'b1);
    wait_start();
    bus.run = 1'b0;
    serve(1, 18'h2A5A3, 1'b1);
    pop_check("conc_drain");
    pop_check("conc_drain");
    check("conc_empty", 32'(bus.empty), 32'd1);

    // Watchdog: silent Wrapper, sticky err, clear-vs-set priority
    bus.run = 1'b1;
    wait_start();
    first_err = 0; first_start = 0; last_start = 0;
    err_sticky = 1'b0; err_setwins = 1'b0;
    for (int k = 1; k <= 2 * TIMEOUT + 2; k++) begin
      @(negedge clk);
      if (bus.err === 1'b1 && first_err == 0) first_err = k;
      if (bus.start === 1'b1) begin
        if (first_start == 0) first_start = k;
        last_start = k;
      end
      if (k == TIMEOUT + 5) err_sticky = bus.err;
      if (k == 2 * TIMEOUT) bus.clr_err = 1'b1;
      if (k == 2 * TIMEOUT + 1) begin
        err_setwins = bus.err;
        bus.clr_err = 1'b0;
      end
    end
    check("to_err_latency", 32'(first_err), 32'(TIMEOUT));
    check("to_reissue", 32'(first_start), 32'(TIMEOUT + 1));
    check("to_second_reissue", 32'(last_start), 32'(2 * TIMEOUT + 2));
    check("to_err_sticky", 32'(err_sticky), 32'd1);
    check("to_set_wins", 32'(err_setwins), 32'd1);
    check("to_no_write", 32'(bus.count), 32'd0);
    check("to_n_done", 32'(bus.n_done), 32'(exp_n_done));
    bus.clr_err = 1'b1;
    bus.run     = 1'b0;
    @(negedge clk);
    bus.clr_err = 1'b0;
    check("clr_err", 32'(bus.err), 32'd0);
    serve(3, 18'h3C0DE, 1'b0);

    // Stray done while idle must not be written
    {bus.intpart, bus.fracpart} = 18'h3FFFF;
    bus.done = 1'b1;
    repeat (2) @(negedge clk);
    bus.done = 1'b0;
    @(negedge clk);
    check("stray_count", 32'(bus.count), 32'(q.size()));
    check("stray_n_done", 32'(bus.n_done), 32'(exp_n_done));
    check("stray_head", 32'(bus.rd_data), 32'(q[0]));
    check("stray_idle", 32'(bus.busy), 32'd0);

    // Reset while a request is in flight
    bus.run = 1'b1;
    wait_start();
    #1 rst = 1'b0;
    #1;
    check("midrst_start", 32'(bus.start), 32'd0);
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_empty", 32'(bus.empty), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_n_done", 32'(bus.n_done), 32'd0);
    q.delete();
    exp_n_done = 8'd0;
    bus.run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(bus.busy), 32'd0);
    check("post_rst_empty", 32'(bus.empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
